fire3_squeeze_ofm_buffer: RTL and testbench

- Receiving end of the fire3_squeeze output interface.
- Captures each parallel DSP_NO-channel output vector on fire3_squeeze_sample into an on-chip pixel buffer.
- After WOUT**2 vectors are stored, returns the ram_feedback handshake to the squeeze layer.
- Replays the stored feature map as a serial one-word-per-cycle ifm stream (pixel-major, channel-minor) for the fire3 expand layers.

---
 rtl/fire_buf_pkg.sv | 27 ++
 rtl/fire_ofm_ram.sv | 28 ++
 rtl/fire3_squeeze_ofm_buffer.sv | 203 ++++++++++++++++++++
 tb/tb_fire3_squeeze_ofm_buffer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fire_buf_pkg.sv
// Shared types and width helpers for the fire3 squeeze output buffer.
package fire_buf_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        FULL = 2'd1,
        DONE = 2'd2
    } buf_state_t;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    // Pointer width for n entries; a single entry still gets a 1-bit pointer.
    function automatic int ptrWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int pixPtrWidth(input int wout);
        return ptrWidth(wout * wout);
    endfunction

    function automatic int chPtrWidth(input int dspNo);
        return ptrWidth(dspNo);
    endfunction

endpackage

// File: rtl/fire_ofm_ram.sv
// Simple dual-port pixel RAM: one write port, one registered read port, no reset.
module fire_ofm_ram #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12,
    parameter int DW    = 256
) (
    input  logic          clk,
    input  logic          i_wrEn,
    input  logic [AW-1:0] i_wrAddr,
    input  logic [DW-1:0] i_wrData,
    input  logic          i_rdEn,
    input  logic [AW-1:0] i_rdAddr,
    output logic [DW-1:0] o_rdData
);

    logic [DW-1:0] r_mem [0:DEPTH-1];

    // Write and registered read share the clock so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
        if (i_rdEn) begin
            o_rdData <= r_mem[i_rdAddr];
        end
    end

endmodule

// File: rtl/fire3_squeeze_ofm_buffer.sv
// Collects fire3 squeeze output vectors, then replays them one word per cycle.
module fire3_squeeze_ofm_buffer
    import fire_buf_pkg::*;
#(
    parameter int WOUT   = 64,
    parameter int DSP_NO = 16,
    parameter int WIDTH  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fire3_squeeze_sample,
    input  logic [WIDTH-1:0] ofm [0:DSP_NO-1],
    input  logic             fire3_squeeze_finish,
    output logic             ram_feedback,
    input  logic             rd_en,
    output logic [WIDTH-1:0] ifm_out,
    output logic             ifm_valid,
    output logic             buf_full,
    output logic             buf_drained,
    output logic             err_early_finish
);

    localparam int DEPTH = WOUT * WOUT;
    localparam int AW    = pixPtrWidth(WOUT);
    localparam int CW    = chPtrWidth(DSP_NO);
    localparam int DW    = DSP_NO * WIDTH;

    localparam logic [AW-1:0] LAST_PIX = AW'(DEPTH - 1);
    localparam logic [CW-1:0] LAST_CH  = CW'(DSP_NO - 1);

    buf_state_t r_state;
    buf_state_t w_nextState;

    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_pixPtr;
    logic [CW-1:0] r_chPtr;

    logic w_wrEn;
    logic w_rdAccept;
    logic w_fillDone;
    logic w_lastRead;

    logic [DW-1:0]    w_wrData;
    logic [DW-1:0]    w_rdData;
    logic [WIDTH-1:0] w_chWords [0:DSP_NO-1];

    logic [CW-1:0]    r_s1Ch;
    logic             r_s1Valid;
    logic             r_s1Last;
    logic [WIDTH-1:0] r_ifmOut;
    logic             r_ifmValid;

    logic r_ramFeedback;
    logic r_bufFull;
    logic r_bufDrained;
    logic r_errEarlyFinish;

    // State register; FILL after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state plus the write/read strobes that the rest of the datapath follows.
    always_comb begin
        w_nextState = r_state;
        w_wrEn      = 1'b0;
        w_rdAccept  = 1'b0;
        w_fillDone  = 1'b0;
        w_lastRead  = 1'b0;
        case (r_state)
            FILL: begin
                if (fire3_squeeze_sample) begin
                    w_wrEn = 1'b1;
                    if (r_wrPtr == LAST_PIX) begin
                        w_fillDone  = 1'b1;
                        w_nextState = FULL;
                    end
                end
            end
            FULL: begin
                if (rd_en) begin
                    w_rdAccept = 1'b1;
                    if ((r_pixPtr == LAST_PIX) && (r_chPtr == LAST_CH)) begin
                        w_lastRead  = 1'b1;
                        w_nextState = DONE;
                    end
                end
            end
            DONE: begin
                w_nextState = DONE;
            end
            default: begin
                w_nextState = FILL;
            end
        endcase
    end

    // Write pointer advances per stored vector; read pointers walk pixel-major, channel-minor.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr  <= '0;
            r_pixPtr <= '0;
            r_chPtr  <= '0;
        end else begin
            if (w_wrEn) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_rdAccept) begin
                if (r_chPtr == LAST_CH) begin
                    r_chPtr  <= '0;
                    r_pixPtr <= r_pixPtr + AW'(1);
                end else begin
                    r_chPtr <= r_chPtr + CW'(1);
                end
            end
        end
    end

    // Pack the channel vector into one RAM word, channel i at bits [i*WIDTH +: WIDTH].
    always_comb begin
        w_wrData = '0;
        for (int i = 0; i < DSP_NO; i++) begin
            w_wrData[i*WIDTH +: WIDTH] = ofm[i];
        end
    end

    fire_ofm_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ram (
        .clk      (clk),
        .i_wrEn   (w_wrEn),
        .i_wrAddr (r_wrPtr),
        .i_wrData (w_wrData),
        .i_rdEn   (w_rdAccept),
        .i_rdAddr (r_pixPtr),
        .o_rdData (w_rdData)
    );

    // Unpack the RAM read word so the channel select is a plain array index.
    always_comb begin
        for (int i = 0; i < DSP_NO; i++) begin
            w_chWords[i] = w_rdData[i*WIDTH +: WIDTH];
        end
    end

    // Read pipeline: channel select and last-word flag travel alongside the RAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Ch     <= '0;
            r_s1Valid  <= 1'b0;
            r_s1Last   <= 1'b0;
            r_ifmOut   <= '0;
            r_ifmValid <= 1'b0;
        end else begin
            r_s1Valid  <= w_rdAccept;
            r_s1Last   <= w_lastRead;
            if (w_rdAccept) begin
                r_s1Ch <= r_chPtr;
            end
            r_ifmValid <= r_s1Valid;
            if (r_s1Valid) begin
                r_ifmOut <= w_chWords[r_s1Ch];
            end
        end
    end

    // Status flags: feedback pulse, full level, sticky drained and early-finish.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ramFeedback    <= 1'b0;
            r_bufFull        <= 1'b0;
            r_bufDrained     <= 1'b0;
            r_errEarlyFinish <= 1'b0;
        end else begin
            r_ramFeedback <= w_fillDone;
            if (w_fillDone) begin
                r_bufFull <= 1'b1;
            end else if (w_lastRead) begin
                r_bufFull <= 1'b0;
            end
            if (r_s1Last) begin
                r_bufDrained <= 1'b1;
            end
            if ((r_state == FILL) && fire3_squeeze_finish) begin
                r_errEarlyFinish <= 1'b1;
            end
        end
    end

    assign ram_feedback     = r_ramFeedback;
    assign ifm_out          = r_ifmOut;
    assign ifm_valid        = r_ifmValid;
    assign buf_full         = r_bufFull;
    assign buf_drained      = r_bufDrained;
    assign err_early_finish = r_errEarlyFinish;

endmodule

// File: tb/tb_fire3_squeeze_ofm_buffer.sv
// Randomized directed bench for the fire3 squeeze output buffer with a transaction-level model.
module tb_fire3_squeeze_ofm_buffer;

    localparam int WOUT   = 4;
    localparam int DSP_NO = 4;
    localparam int WIDTH  = 16;
    localparam int DEPTH  = WOUT * WOUT;
    localparam int TOTAL  = DEPTH * DSP_NO;

    logic             clk;
    logic             rst;
    logic             sample;
    logic [WIDTH-1:0] ofmVec [0:DSP_NO-1];
    logic             finish;
    logic             ramFeedback;
    logic             rdEn;
    logic [WIDTH-1:0] ifmOut;
    logic             ifmValid;
    logic             bufFull;
    logic             bufDrained;
    logic             errEarlyFinish;

    fire3_squeeze_ofm_buffer #(
        .WOUT   (WOUT),
        .DSP_NO (DSP_NO),
        .WIDTH  (WIDTH)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .fire3_squeeze_sample (sample),
        .ofm                  (ofmVec),
        .fire3_squeeze_finish (finish),
        .ram_feedback         (ramFeedback),
        .rd_en                (rdEn),
        .ifm_out              (ifmOut),
        .ifm_valid            (ifmValid),
        .buf_full             (bufFull),
        .buf_drained          (bufDrained),
        .err_early_finish     (errEarlyFinish)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int               due;
        logic [WIDTH-1:0] word;
        bit               last;
    } pend_t;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [WIDTH-1:0] mMem [0:DEPTH-1][0:DSP_NO-1];
    int    mStored;
    int    mReads;
    bit    mFull;
    bit    mDone;
    bit    mErr;
    bit    mDrained;
    int    fbDue;
    pend_t pq [$];
    int    fbSeen;
    int    ffffSeen;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic clearModel();
        mStored  = 0;
        mReads   = 0;
        mFull    = 0;
        mDone    = 0;
        mErr     = 0;
        mDrained = 0;
        fbDue    = -1;
        pq.delete();
    endtask

    task automatic checkCycle();
        bit               expValid;
        logic [WIDTH-1:0] expWord;
        expValid = 0;
        expWord  = '0;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            expValid = 1;
            expWord  = pq[0].word;
            if (pq[0].last) mDrained = 1;
            void'(pq.pop_front());
        end
        if (ramFeedback === 1'b1) fbSeen++;
        if (ifmValid === 1'b1 && ifmOut === 16'hFFFF) ffffSeen++;
        checkOutput("ram_feedback", ramFeedback, (cyc == fbDue));
        checkOutput("ifm_valid", ifmValid, expValid);
        if (expValid) checkOutput("ifm_out", ifmOut, expWord);
        checkOutput("buf_full", bufFull, mFull);
        checkOutput("buf_drained", bufDrained, mDrained);
        checkOutput("err_early_finish", errEarlyFinish, mErr);
    endtask

    task automatic applyStimulus(input bit smp, input bit fin, input bit rd);
        pend_t p;
        sample = smp;
        finish = fin;
        rdEn   = rd;
        if (!mFull && !mDone) begin
            if (fin) mErr = 1;
            if (smp) begin
                for (int i = 0; i < DSP_NO; i++) mMem[mStored][i] = ofmVec[i];
                mStored++;
                if (mStored == DEPTH) begin
                    mFull = 1;
                    fbDue = cyc + 1;
                end
            end
        end else if (mFull && rd) begin
            p.due  = cyc + 2;
            p.word = mMem[mReads / DSP_NO][mReads % DSP_NO];
            p.last = (mReads == TOTAL - 1);
            pq.push_back(p);
            mReads++;
            if (mReads == TOTAL) begin
                mFull = 0;
                mDone = 1;
            end
        end
        tick();
        checkCycle();
    endtask

    task automatic resetDut();
        rst    = 1'b1;
        sample = 1'b0;
        finish = 1'b0;
        rdEn   = 1'b0;
        tick();
        rst = 1'b0;
        clearModel();
        fbSeen   = 0;
        ffffSeen = 0;
        checkOutput("reset_ifm_out", ifmOut, 0);
        checkCycle();
    endtask

    task automatic randomOfm();
        for (int i = 0; i < DSP_NO; i++) ofmVec[i] = WIDTH'($urandom);
    endtask

    // dataMode: 0 = pix*DSP_NO+ch, 1 = random, 2 = ramp with 0xFFFF beyond the buffer depth
    task automatic fillBuffer(input int nSamples, input int dataMode, input int finishAfter);
        int gap;
        bit rdr;
        for (int k = 0; k < nSamples; k++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                randomOfm();
                rdr = (!mFull && !mDone) ? 1'($urandom_range(0, 1)) : 1'b0;
                applyStimulus(1'b0, 1'b0, rdr);
            end
            for (int i = 0; i < DSP_NO; i++) begin
                if (dataMode == 1) ofmVec[i] = WIDTH'($urandom);
                else if (dataMode == 2 && k >= DEPTH) ofmVec[i] = 16'hFFFF;
                else ofmVec[i] = WIDTH'(k * DSP_NO + i);
            end
            rdr = (!mFull && !mDone) ? 1'($urandom_range(0, 1)) : 1'b0;
            applyStimulus(1'b1, 1'b0, rdr);
            if (k + 1 == finishAfter) begin
                randomOfm();
                applyStimulus(1'b0, 1'b1, 1'b0);
            end
        end
    endtask

    // pattern: 0 = continuous, 1 = 1,0,0,1 repeating, 2 = random
    task automatic drainBuffer(input int pattern, input int stopAfter);
        int budget;
        bit rd;
        budget = 0;
        while (!mDone && mReads < stopAfter && budget < 1000) begin
            case (pattern)
                0:       rd = 1'b1;
                1:       rd = ((budget % 4) == 0) || ((budget % 4) == 3);
                default: rd = 1'($urandom_range(0, 1));
            endcase
            ofmVec[0] = 16'hFFFF;
            for (int i = 1; i < DSP_NO; i++) ofmVec[i] = 16'hFFFF;
            applyStimulus(1'($urandom_range(0, 1)), 1'b0, rd);
            budget++;
        end
        if (budget >= 1000) begin
            checks++;
            errors++;
            $error("[TB] FAIL drain_budget: observed=%0d reads expected=%0d", mReads, stopAfter);
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            randomOfm();
            applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        end
    endtask

    // Watchdog so a stuck simulation still ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence of test phases.
    initial begin
        rst    = 1'b1;
        sample = 1'b0;
        finish = 1'b0;
        rdEn   = 1'b0;
        for (int i = 0; i < DSP_NO; i++) ofmVec[i] = '0;
        clearModel();
        fbSeen   = 0;
        ffffSeen = 0;
        @(negedge clk);

        $display("[TB] phase 1/2: ramp fill and continuous drain");
        resetDut();
        fillBuffer(DEPTH, 0, -1);
        idleCycles(2);
        drainBuffer(0, TOTAL);
        idleCycles(4);
        checkOutput("fb_count_p1", fbSeen, 1);

        $display("[TB] phase 3: throttled drain");
        resetDut();
        fillBuffer(DEPTH, 0, -1);
        drainBuffer(1, TOTAL);
        idleCycles(4);

        $display("[TB] phase 4: overflow samples");
        resetDut();
        fillBuffer(DEPTH + 4, 2, -1);
        drainBuffer(2, TOTAL);
        idleCycles(4);
        checkOutput("fb_count_p4", fbSeen, 1);
        checkOutput("ffff_words_p4", ffffSeen, 0);

        $display("[TB] phase 5: early finish");
        resetDut();
        fillBuffer(DEPTH, 1, 5);
        drainBuffer(2, TOTAL);
        idleCycles(4);
        checkOutput("fb_count_p5", fbSeen, 1);

        $display("[TB] phase 6: reset mid-drain then fresh data");
        resetDut();
        fillBuffer(DEPTH, 0, -1);
        drainBuffer(0, 10);
        resetDut();
        checkOutput("reset_buf_full_p6", bufFull, 0);
        fillBuffer(DEPTH, 1, -1);
        drainBuffer(2, TOTAL);
        idleCycles(4);
        checkOutput("fb_count_p6", fbSeen, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
